// File: rtl/lcm_pkg.sv
// Shared types and defaults for the GCD/LCM engine.
// Imported by the interface, divider and top level.
package lcm_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      GCD,
      DIV,
      OUT
   } state_t;

endpackage

// File: rtl/lcm_if.sv
// Operand/result bundle between a producer and lcm_core.
// The producer holds operands; the core pulses vld_out per result.
interface lcm_if
   import lcm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [DATA_W-1:0]   A;
   logic [DATA_W-1:0]   B;
   logic                vld_in;
   logic [2*DATA_W-1:0] lcm_out;
   logic [DATA_W-1:0]   mcd_out;
   logic                vld_out;

   modport master (
      output A,
      output B,
      output vld_in,
      input  lcm_out,
      input  mcd_out,
      input  vld_out
   );

   modport slave (
      input  A,
      input  B,
      input  vld_in,
      output lcm_out,
      output mcd_out,
      output vld_out
   );

endinterface

// File: rtl/lcm_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// o_done is held until the cycle after it is first seen.
module lcm_div
   import lcm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_dvd,
   input  logic [DATA_W-1:0] i_dvs,
   output logic              o_done,
   output logic [DATA_W-1:0] o_quo
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W);

   logic              r_busy;
   logic [CW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_dvs;

   logic [DATA_W:0]   w_sh;
   logic              w_ge;
   logic [DATA_W-1:0] w_diff;

   // One restoring step: shift in the next dividend bit, try to subtract.
   always_comb begin
      w_sh   = {r_rem, r_quo[DATA_W-1]};
      w_ge   = (w_sh >= {1'b0, r_dvs});
      w_diff = w_sh[DATA_W-1:0] - r_dvs;
   end

   // Iteration counter, partial remainder and quotient shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CNT_INIT;
         r_rem  <= '0;
         r_quo  <= i_dvd;
         r_dvs  <= i_dvs;
      end else if (r_busy) begin
         if (r_cnt != '0) begin
            r_rem <= w_ge ? w_diff : w_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done = r_busy && (r_cnt == '0);
   assign o_quo  = r_quo;

endmodule

// File: rtl/lcm_core.sv
// Iterative GCD (subtractive Euclid) and LCM = a * (b / gcd).
// One operand pair in flight; results held until the next pulse.
module lcm_core
   import lcm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input logic  clk,
   input logic  rst_n,
   lcm_if.slave bus
);

   state_t r_state;
   state_t w_next;

   logic [DATA_W-1:0]   r_a_org;
   logic [DATA_W-1:0]   r_b_org;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_g;
   logic [2*DATA_W-1:0] r_lcm;
   logic [DATA_W-1:0]   r_mcd;
   logic                r_vld;

   logic                w_gcd_done;
   logic [DATA_W-1:0]   w_g;
   logic                w_div_start;
   logic                w_div_done;
   logic [DATA_W-1:0]   w_quo;
   logic [DATA_W-1:0]   w_q;
   logic [2*DATA_W-1:0] w_prod;
   logic                w_emit;

   // Euclid terminates on equality or a zero; a zero operand yields the other.
   always_comb begin
      w_gcd_done  = (r_a == r_b) || (r_a == '0) || (r_b == '0);
      w_g         = (r_a == '0) ? r_b : r_a;
      w_div_start = (r_state == GCD) && w_gcd_done && (w_g != '0);
      w_q         = (r_g == '0) ? '0 : w_quo;
      w_prod      = {{DATA_W{1'b0}}, r_a_org} * {{DATA_W{1'b0}}, w_q};
   end

   lcm_div #(
      .DATA_W (DATA_W)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_div_start),
      .i_dvd   (r_b_org),
      .i_dvs   (w_g),
      .o_done  (w_div_done),
      .o_quo   (w_quo)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode; a zero gcd bypasses the divider.
   always_comb begin
      w_next = r_state;
      w_emit = 1'b0;
      case (r_state)
         IDLE: if (bus.vld_in) w_next = GCD;
         GCD:  if (w_gcd_done) w_next = DIV;
         DIV: begin
            if ((r_g == '0) || w_div_done) begin
               w_next = OUT;
               w_emit = 1'b1;
            end
         end
         OUT:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture and one Euclid subtraction per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_org <= '0;
         r_b_org <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_g     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.vld_in) begin
                  r_a_org <= bus.A;
                  r_b_org <= bus.B;
                  r_a     <= bus.A;
                  r_b     <= bus.B;
               end
            end
            GCD: begin
               if (w_gcd_done)     r_g <= w_g;
               else if (r_a > r_b) r_a <= r_a - r_b;
               else                r_b <= r_b - r_a;
            end
            default: ;
         endcase
      end
   end

   // Result registers load on entry to OUT so they are valid with vld_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcd <= '0;
         r_lcm <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= w_emit;
         if (w_emit) begin
            r_mcd <= r_g;
            r_lcm <= w_prod;
         end
      end
   end

   assign bus.mcd_out = r_mcd;
   assign bus.lcm_out = r_lcm;
   assign bus.vld_out = r_vld;

endmodule

// File: tb/tb_lcm_core.sv
// Directed bench for lcm_core with a result scoreboard.
// Expected gcd/lcm/latency come from a reference model in the bench.
module tb_lcm_core;

   localparam int DW  = 8;
   localparam int BUD = 600;

   typedef struct {
      logic [DW-1:0]   mcd;
      logic [2*DW-1:0] lcm;
      int              lat;
   } exp_t;

   logic clk;
   logic rst_n;

   lcm_if #(.DATA_W(DW)) bus ();

   lcm_core #(.DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t            sb[$];
   int              tests;
   int              fails;
   logic [DW-1:0]   last_mcd;
   logic [2*DW-1:0] last_lcm;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gcd_ref(input int a, input int b);
      int x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int steps_ref(input int a, input int b);
      int x, y, k;
      x = a;
      y = b;
      k = 0;
      while (x != y && x != 0 && y != 0) begin
         if (x > y) x = x - y;
         else       y = y - x;
         k++;
      end
      return k;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int a, input int b);
      exp_t e;
      int g;
      g     = gcd_ref(a, b);
      e.mcd = DW'(g);
      e.lcm = (a == 0 || b == 0) ? '0 : (2*DW)'((a / g) * b);
      e.lat = 1 + steps_ref(a, b) + 2 + ((g == 0) ? 0 : DW);
      sb.push_back(e);
   endtask

   task automatic hold_check();
      @(negedge clk);
      check("hold_vld", int'(bus.vld_out), 0);
      check("hold_mcd", int'(bus.mcd_out), int'(last_mcd));
      check("hold_lcm", int'(bus.lcm_out), int'(last_lcm));
   endtask

   task automatic wait_result(input int start);
      int   cnt;
      bit   seen;
      exp_t e;
      cnt  = start;
      seen = 0;
      while (!seen && cnt < BUD) begin
         @(negedge clk);
         cnt++;
         if (bus.vld_out === 1'b1) seen = 1;
      end
      check("vld_seen", int'(seen), 1);
      check("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (seen) begin
            check("mcd", int'(bus.mcd_out), int'(e.mcd));
            check("lcm", int'(bus.lcm_out), int'(e.lcm));
            check("latency", cnt, e.lat);
            last_mcd = e.mcd;
            last_lcm = e.lcm;
         end
      end
   endtask

   task automatic run_pair(input int a, input int b);
      bus.A = DW'(a);
      bus.B = DW'(b);
      push_exp(a, b);
      hold_check();
      wait_result(0);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      last_mcd   = '0;
      last_lcm   = '0;
      rst_n      = 1'b0;
      bus.vld_in = 1'b1;
      bus.A      = 8'd6;
      bus.B      = 8'd7;

      #12;
      check("rst_vld", int'(bus.vld_out), 0);
      check("rst_mcd", int'(bus.mcd_out), 0);
      check("rst_lcm", int'(bus.lcm_out), 0);

      @(negedge clk);
      rst_n = 1'b1;
      push_exp(6, 7);
      repeat (4) @(negedge clk);
      bus.A = 8'd12;
      bus.B = 8'd8;
      push_exp(12, 8);
      wait_result(4);

      hold_check();
      wait_result(0);

      run_pair(15, 20);
      run_pair(255, 255);
      run_pair(0, 9);
      run_pair(0, 0);
      run_pair(255, 1);
      run_pair(255, 254);

      bus.A = 8'd200;
      bus.B = 8'd3;
      hold_check();
      repeat (10) @(negedge clk);
      check("pre_rst_vld", int'(bus.vld_out), 0);
      rst_n = 1'b0;
      #1;
      check("midrst_vld", int'(bus.vld_out), 0);
      check("midrst_mcd", int'(bus.mcd_out), 0);
      check("midrst_lcm", int'(bus.lcm_out), 0);
      repeat (3) @(negedge clk);
      bus.A = 8'd9;
      bus.B = 8'd6;
      push_exp(9, 6);
      rst_n = 1'b1;
      wait_result(0);

      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lcm_core.md
# lcm_core

Iterative integer arithmetic block that takes two unsigned `DATA_W`-bit operands and returns their greatest common divisor (`mcd_out`) and least common multiple (`lcm_out`). It is a multi-cycle, non-pipelined engine: it accepts one operand pair, computes, pulses `vld_out`, then accepts the next pair. It sits behind any producer that can hold operands stable while it is idle.

## Interface

**Parameters**
- `DATA_W`, default 8: operand width. GCD is `DATA_W` bits; LCM is `2*DATA_W` bits.

**Ports**
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; single clock domain, asynchronous, active-low.
- `A`  in  `DATA_W`  operand A, unsigned.
- `B`  in  `DATA_W`  operand B, unsigned.
- `vld_in`  in  1  operands valid. Sampled only in IDLE.
- `lcm_out`  out  `2*DATA_W`  least common multiple, registered.
- `mcd_out`  out  `DATA_W`  greatest common divisor, registered.
- `vld_out`  out  1  one-cycle pulse when `lcm_out`/`mcd_out` update.

## Operation

**FSM states:** IDLE, GCD, DIV, OUT.

- **IDLE**
  - If `vld_in`=1: latch `A`, `B` into `a_org`/`b_org` and working regs `a`/`b`; go to GCD.
  - `vld_in` is ignored in every other state. There is no backpressure; the source must hold or re-present operands.
- **GCD** (subtractive Euclid), one step per cycle:
  - If `a`>`b`: `a` -= `b`.
  - If `b`>`a`: `b` -= `a`.
  - If `a`==`b`, or either is 0: latch `g`, then go to DIV. `g` = `a` if `a`==`b`; `g` = the nonzero operand if one is 0; `g` = 0 if both are 0.
- **DIV**
  - If `g`==0, skip directly to OUT with quotient 0.
  - Otherwise, restoring shift-subtract division `q = b_org / g`, exactly `DATA_W` cycles. The remainder is always 0 and is discarded.
- **OUT**
  - Register `mcd_out`=`g` and `lcm_out`=`a_org*q` (full `2*DATA_W` product, no overflow possible).
  - Assert `vld_out`=1 for this single cycle; next state IDLE.
- **Zero operands:** `lcm_out`=0 if either operand is 0; `mcd_out`=the other operand; gcd(0,0)=0.
- **Output hold:** `lcm_out`/`mcd_out` keep the last result until the next OUT.

## Timing

- **Reset** (async assert, synchronous-safe deassert): state IDLE, all internal regs 0, `lcm_out`=0, `mcd_out`=0, `vld_out`=0.
- **Reset mid-operation:** computation aborted, nothing emitted, outputs cleared.
- **Latency:** capture edge E0. `vld_out` is high in the cycle following edge E0 + k + 1 + `DATA_W` + 1, where k is the number of subtraction steps. With `g`==0 the `DATA_W` term drops.
  - Example, (6,7), `DATA_W`=8: k=6, so `vld_out` follows edge E0+16.
  - Worst case k = 2^`DATA_W`−2, e.g. (255,1).
- **Back-to-back:** after OUT, one IDLE cycle precedes the next capture. With `vld_in` held high, consecutive results are separated by their latency + 1 cycle.
- **Operand changes while busy:** no effect on the current result. The value present in the next IDLE cycle is captured.

## Structure

- **Shared package `lcm_pkg`:**
  - default `DATA_W`
  - state enum {IDLE, GCD, DIV, OUT}
- **Sub-module `lcm_div`:** sequential restoring divider (`DATA_W`/`DATA_W`, start/done handshake), instantiated for the DIV phase.
- **Top level:** FSM, GCD datapath, and the final multiplier.

## Test plan

- **Reset:** `rst_n`=0 for 10 ns with `vld_in`=1 → all outputs 0, no `vld_out` pulse.
- **Coprime:** release reset, A=6, B=7, `vld_in` held 1 → `vld_out` pulse with `mcd_out`=1, `lcm_out`=42, 16 cycles after capture; outputs hold afterwards.
- **Common factor:** A=12, B=8 presented mid-operation → the running result is unaffected; next result `mcd_out`=4, `lcm_out`=24.
- **Next pair:** A=15, B=20 → `mcd_out`=5, `lcm_out`=60. Also A=255, B=255 → `mcd_out`=255, `lcm_out`=255.
- **Boundaries:**
  - A=0, B=9 → `mcd_out`=9, `lcm_out`=0.
  - A=0, B=0 → both 0.
  - A=255, B=1 → `mcd_out`=1, `lcm_out`=255 within the worst-case latency bound.
  - A=255, B=254 → `lcm_out`=64770.
- **Mid-op reset:** pulse `rst_n` low during the GCD phase → no `vld_out`, outputs 0. After release the next pair computes correctly.
